ex_mem_reg: RTL and testbench

- EX/MEM pipeline register that feeds the memory-access stage.
- Captures EX-stage control, ALU result, store data and destination register each cycle.
- Supports stall (hold) and flush (bubble insert).
- Computes a registered store-data forward select (forwardC) so the memory stage can take a store operand produced by the immediately preceding instruction from the write-back value.
- Keeps saturating load/store retire counters for debug.

---
 rtl/ex_mem_reg.sv | 124 ++++++++++++
 tb/tb_ex_mem_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures EX control/data, computes store-data forward select, counts retired loads/stores.
// Latency: 1 cycle from ex_* inputs to *_out; every output is driven straight from a flop.
// Backpressure: stall holds every register (MEM/WB frozen alongside); flush overrides stall and inserts a bubble.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   stall, flush          hold / bubble-insert controls (flush wins)
//   ex_valid, ex_*        EX-stage instruction: control bits, PC_BL, ALU result, store data, Rd, Rt
//   mem_valid, *_out      registered MEM-stage instruction
//   ALU_FF                registered store data
//   forwardC              00 = use ALU_FF, 01 = use WB write data for the store operand
//   load_count/store_count saturating counts of loads/stores captured into MEM
module ex_mem_reg #(
  parameter int DW = 64,
  parameter int RW = 5,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic          ex_RegWrite,
  input  logic          ex_MemRead,
  input  logic          ex_MemWrite,
  input  logic          ex_MemtoReg,
  input  logic          ex_BrLink,
  input  logic [DW-1:0] ex_PC_BL,
  input  logic [DW-1:0] ex_ALU_Result,
  input  logic [DW-1:0] ex_Store_Data,
  input  logic [RW-1:0] ex_Rd,
  input  logic [RW-1:0] ex_Rt,
  output logic          mem_valid,
  output logic          RegWrite_out,
  output logic          MemRead_out,
  output logic          MemWrite_out,
  output logic          MemtoReg_out,
  output logic          BrLink_out,
  output logic [DW-1:0] PC_BL_out,
  output logic [DW-1:0] ALU_Result_out,
  output logic [DW-1:0] ALU_FF,
  output logic [RW-1:0] Rd_out,
  output logic [1:0]    forwardC,
  output logic [CW-1:0] load_count,
  output logic [CW-1:0] store_count
);

  localparam logic [RW-1:0] XZR     = RW'(31);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic capture;
  logic fwd_hit;
  logic count_load;
  logic count_store;

  assign capture = !flush && !stall;

  // The instruction now in MEM reaches WB next cycle, so a store entering MEM
  // that reads its result must take the WB write data instead of ALU_FF.
  // Older producers were already resolved by EX forwarding.
  assign fwd_hit = ex_valid && ex_MemWrite && mem_valid && RegWrite_out &&
                   (Rd_out == ex_Rt) && (ex_Rt != XZR);

  assign count_load  = capture && ex_valid && ex_MemRead;
  assign count_store = capture && ex_valid && ex_MemWrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      RegWrite_out   <= 1'b0;
      MemRead_out    <= 1'b0;
      MemWrite_out   <= 1'b0;
      MemtoReg_out   <= 1'b0;
      BrLink_out     <= 1'b0;
      PC_BL_out      <= '0;
      ALU_Result_out <= '0;
      ALU_FF         <= '0;
      Rd_out         <= '0;
      forwardC       <= 2'b00;
    end else if (flush) begin
      mem_valid      <= 1'b0;
      RegWrite_out   <= 1'b0;
      MemRead_out    <= 1'b0;
      MemWrite_out   <= 1'b0;
      MemtoReg_out   <= 1'b0;
      BrLink_out     <= 1'b0;
      PC_BL_out      <= '0;
      ALU_Result_out <= '0;
      ALU_FF         <= '0;
      Rd_out         <= '0;
      forwardC       <= 2'b00;
    end else if (!stall) begin
      // Control is qualified by ex_valid so a bubble never writes or accesses
      // memory; data fields are don't-care for a bubble and load unmasked.
      mem_valid      <= ex_valid;
      RegWrite_out   <= ex_valid && ex_RegWrite;
      MemRead_out    <= ex_valid && ex_MemRead;
      MemWrite_out   <= ex_valid && ex_MemWrite;
      MemtoReg_out   <= ex_valid && ex_MemtoReg;
      BrLink_out     <= ex_valid && ex_BrLink;
      PC_BL_out      <= ex_PC_BL;
      ALU_Result_out <= ex_ALU_Result;
      ALU_FF         <= ex_Store_Data;
      Rd_out         <= ex_Rd;
      forwardC       <= fwd_hit ? 2'b01 : 2'b00;
    end
  end

  // Saturating debug counters; held on stall, untouched by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (count_load && (load_count != CNT_MAX)) begin
        load_count <= load_count + CW'(1);
      end
      if (count_store && (store_count != CNT_MAX)) begin
        store_count <= store_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  localparam int DW = 64;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall, flush;
  logic          ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_BrLink;
  logic [DW-1:0] ex_PC_BL, ex_ALU_Result, ex_Store_Data;
  logic [RW-1:0] ex_Rd, ex_Rt;
  logic          mem_valid, RegWrite_out, MemRead_out, MemWrite_out, MemtoReg_out, BrLink_out;
  logic [DW-1:0] PC_BL_out, ALU_Result_out, ALU_FF;
  logic [RW-1:0] Rd_out;
  logic [1:0]    forwardC;
  logic [CW-1:0] load_count, store_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_BrLink(ex_BrLink),
    .ex_PC_BL(ex_PC_BL), .ex_ALU_Result(ex_ALU_Result), .ex_Store_Data(ex_Store_Data),
    .ex_Rd(ex_Rd), .ex_Rt(ex_Rt),
    .mem_valid(mem_valid), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .MemtoReg_out(MemtoReg_out), .BrLink_out(BrLink_out),
    .PC_BL_out(PC_BL_out), .ALU_Result_out(ALU_Result_out), .ALU_FF(ALU_FF),
    .Rd_out(Rd_out), .forwardC(forwardC), .load_count(load_count), .store_count(store_count)
  );

  // Reference model: the instruction sitting in MEM plus two plain integer counters.
  typedef struct packed {
    logic          vld, rw, mr, mw, m2r, bl;
    logic [DW-1:0] pc, alu, sd;
    logic [RW-1:0] rd;
    logic [1:0]    fc;
  } instr_t;

  instr_t m;
  int lc, sc;

  task automatic model_reset();
    m  = '0;
    lc = 0;
    sc = 0;
  endtask

  task automatic model_edge();
    instr_t n;
    if (reset) begin
      model_reset();
    end else if (flush) begin
      m = '0;
    end else if (!stall) begin
      n     = '0;
      n.vld = ex_valid;
      if (ex_valid) begin
        n.rw  = ex_RegWrite;
        n.mr  = ex_MemRead;
        n.mw  = ex_MemWrite;
        n.m2r = ex_MemtoReg;
        n.bl  = ex_BrLink;
        // A store reading the register just written by the instruction now in MEM.
        if (ex_MemWrite && m.vld && m.rw && (m.rd == ex_Rt) && (ex_Rt != 5'd31))
          n.fc = 2'b01;
        if (ex_MemRead)  lc = (lc < CMAX) ? lc + 1 : CMAX;
        if (ex_MemWrite) sc = (sc < CMAX) ? sc + 1 : CMAX;
      end
      n.pc  = ex_PC_BL;
      n.alu = ex_ALU_Result;
      n.sd  = ex_Store_Data;
      n.rd  = ex_Rd;
      m = n;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":mem_valid"}, 64'(mem_valid),      64'(m.vld));
    chk({tag, ":RegWrite"},  64'(RegWrite_out),   64'(m.rw));
    chk({tag, ":MemRead"},   64'(MemRead_out),    64'(m.mr));
    chk({tag, ":MemWrite"},  64'(MemWrite_out),   64'(m.mw));
    chk({tag, ":MemtoReg"},  64'(MemtoReg_out),   64'(m.m2r));
    chk({tag, ":BrLink"},    64'(BrLink_out),     64'(m.bl));
    chk({tag, ":PC_BL"},     PC_BL_out,           m.pc);
    chk({tag, ":ALU"},       ALU_Result_out,      m.alu);
    chk({tag, ":ALU_FF"},    ALU_FF,              m.sd);
    chk({tag, ":Rd"},        64'(Rd_out),         64'(m.rd));
    chk({tag, ":forwardC"},  64'(forwardC),       64'(m.fc));
    chk({tag, ":load_cnt"},  64'(load_count),     64'(lc));
    chk({tag, ":store_cnt"}, 64'(store_count),    64'(sc));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic mr, input logic mw,
                        input logic m2r, input logic bl, input logic [RW-1:0] rd,
                        input logic [RW-1:0] rt);
    ex_valid = v; ex_RegWrite = rw; ex_MemRead = mr; ex_MemWrite = mw;
    ex_MemtoReg = m2r; ex_BrLink = bl; ex_Rd = rd; ex_Rt = rt;
    ex_PC_BL = {$urandom, $urandom};
    ex_ALU_Result = {$urandom, $urandom};
    ex_Store_Data = {$urandom, $urandom};
  endtask

  task automatic rand_ex();
    int op;
    logic [RW-1:0] rd, rt;
    op = $urandom_range(0, 4);
    rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    rt = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    case (op)
      0:       set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rd, rt);   // ALU op
      1:       set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rd, rt);   // load
      2:       set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rd, rt);   // store
      3:       set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rd, rt);   // BL
      default: set_ex(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), rd, rt);
    endcase
  endtask

  initial begin
    // Reset held across edges
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd9);
    model_reset();
    step("reset0");
    step("reset1");
    reset = 1'b0;

    // Basic capture
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0);
    ex_ALU_Result = 64'h1000;
    step("basic");
    chk("basic_alu_const", ALU_Result_out, 64'h1000);
    chk("basic_rd_const", 64'(Rd_out), 64'd5);
    chk("basic_fc_const", 64'(forwardC), 64'd0);

    // ADD X3 then STUR Rt=3 forwards
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0);
    step("add_x3");
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd3);
    step("stur_x3");
    chk("stur_x3_fc_const", 64'(forwardC), 64'd1);
    chk("stur_x3_sc_const", 64'(store_count), 64'd1);

    // XZR never forwards
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 5'd0);
    step("add_xzr");
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd31);
    step("stur_xzr");
    chk("stur_xzr_fc_const", 64'(forwardC), 64'd0);

    // LDUR X7 then STUR Rt=7
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0);
    step("ldur_x7");
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd7);
    step("stur_x7");
    chk("ld_st_fc_const", 64'(forwardC), 64'd1);
    chk("ld_st_lc_const", 64'(load_count), 64'd1);
    chk("ld_st_sc_const", 64'(store_count), 64'd3);

    // Producer two back gives no forward
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0);
    step("add_x4");
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 5'd0);
    step("add_x6");
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd4);
    step("stur_x4_far");
    chk("far_fc_const", 64'(forwardC), 64'd0);

    // Stall for 3 cycles while EX keeps changing
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      step("stall");
    end
    chk("stall_fc_held", 64'(forwardC), 64'd0);

    // Stall + flush together: flush wins, counters unchanged
    stall = 1'b0;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0);
    step("pre_flush_a");
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd2);
    step("pre_flush_b");
    stall = 1'b1; flush = 1'b1;
    set_ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 5'd2);
    step("stall_flush");
    chk("flush_mem_valid_const", 64'(mem_valid), 64'd0);
    chk("flush_memwrite_const", 64'(MemWrite_out), 64'd0);
    chk("flush_sc_const", 64'(store_count), 64'd5);
    stall = 1'b0; flush = 1'b0;

    // Invalid instruction: controls masked, data captured
    set_ex(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 5'd8);
    step("invalid");

    // Saturation: 20 consecutive valid loads
    for (int i = 0; i < 20; i++) begin
      set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'($urandom_range(0, 30)), 5'd0);
      step("sat_load");
    end
    chk("sat_lc_const", 64'(load_count), 64'd15);

    // Asynchronous reset mid-cycle with a valid instruction held
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 5'd3);
    step("pre_areset");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("areset_midcycle");
    chk("areset_lc_const", 64'(load_count), 64'd0);
    step("areset_edge");
    reset = 1'b0;

    // Randomized traffic with occasional stall/flush
    for (int i = 0; i < 400; i++) begin
      rand_ex();
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
